// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and default widths for the serial pattern detector controller.
package seq_det_ctrl_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int TMO_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HUNT   = 2'b01,
    ST_REPORT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    STAT_DONE    = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_ABORTED = 2'b10
  } status_t;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Command / serial / result bundle for seq_det_ctrl.
// Optional macro SEQ_DET_CTRL_MASK_EN adds cfg_mask (don't-care bits in the compare).
//
// Handshake rule for both cfg_* and res_*: a transfer happens on a rising edge
// where valid && ready are both high; the source holds its payload stable
// while valid is high and ready is low, and ready never depends on valid.
interface seq_det_ctrl_if
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_count;
  logic [TMO_W-1:0] cfg_timeout;
`ifdef SEQ_DET_CTRL_MASK_EN
  logic [PAT_W-1:0] cfg_mask;
`endif
  logic             abort;
  logic             bit_valid;
  logic             bit_in;
  logic             det_pulse;
  logic             res_valid;
  logic             res_ready;
  logic [1:0]       res_status;
  logic [CNT_W-1:0] res_matches;
  logic             busy;

  modport master (
    output cfg_valid, cfg_pattern, cfg_count, cfg_timeout,
`ifdef SEQ_DET_CTRL_MASK_EN
    output cfg_mask,
`endif
    output abort, bit_valid, bit_in, res_ready,
    input  cfg_ready, det_pulse, res_valid, res_status, res_matches, busy
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_count, cfg_timeout,
`ifdef SEQ_DET_CTRL_MASK_EN
    input  cfg_mask,
`endif
    input  abort, bit_valid, bit_in, res_ready,
    output cfg_ready, det_pulse, res_valid, res_status, res_matches, busy
  );

endinterface

// File: rtl/seq_det_shift.sv
// Shift register, fill counter and comparator for the serial matcher.
// Newest bit enters at the LSB, so the MSB of the window is the oldest bit.
// Optional macro SEQ_DET_CTRL_MASK_EN makes mask=0 bits don't-care.
module seq_det_shift #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_DET_CTRL_MASK_EN
  input  logic [PAT_W-1:0] mask,
`endif
  output logic             match
);
  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  sr;
  logic [PAT_W-1:0]  sr_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              eq;

  assign sr_next   = {sr[PAT_W-2:0], bit_in};
  assign fill_next = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);

`ifdef SEQ_DET_CTRL_MASK_EN
  assign eq = ((sr_next ^ pattern) & mask) == '0;
`else
  assign eq = (sr_next == pattern);
`endif

  // A match needs a full window after this shift, so early bits cannot fake one.
  assign match = shift_en && (fill_next == FILL_W'(PAT_W)) && eq;

  // Window and fill count advance only on qualified bits; clear starts a new command.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr   <= '0;
      fill <= '0;
    end else if (shift_en) begin
      sr   <= sr_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-time controller for the serial pattern detector: accepts a command,
// hunts for overlapping matches, and returns one result record per command.
// Optional macro SEQ_DET_CTRL_MASK_EN latches a per-bit compare mask.
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus,
  output state_t        fsm_state
);
  state_t           state;
  logic [PAT_W-1:0] pattern_q;
`ifdef SEQ_DET_CTRL_MASK_EN
  logic [PAT_W-1:0] mask_q;
`endif
  logic [CNT_W-1:0] target_q;
  logic [TMO_W-1:0] timeout_q;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [TMO_W-1:0] timer;
  logic             cfg_ready_r;
  logic             det_r;
  logic             res_valid_r;
  logic             busy_r;
  status_t          status_r;
  logic [CNT_W-1:0] matches_r;
  logic             accept;
  logic             shift_en;
  logic             match;
  logic             expire;

  assign accept   = (state == ST_IDLE) && bus.cfg_valid;
  assign shift_en = (state == ST_HUNT) && bus.bit_valid;
  assign expire   = (timeout_q != '0) && ((timer + TMO_W'(1)) == timeout_q);

  seq_det_shift #(.PAT_W(PAT_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en (shift_en),
    .bit_in   (bus.bit_in),
    .pattern  (pattern_q),
`ifdef SEQ_DET_CTRL_MASK_EN
    .mask     (mask_q),
`endif
    .match    (match)
  );

  // Saturating match count including a match completed this cycle.
  always_comb begin
    cnt_next = match_cnt;
    if (match && (match_cnt != '1)) cnt_next = match_cnt + CNT_W'(1);
  end

  // Controller FSM with registered handshake, pulse and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pattern_q   <= '0;
`ifdef SEQ_DET_CTRL_MASK_EN
      mask_q      <= '0;
`endif
      target_q    <= '0;
      timeout_q   <= '0;
      match_cnt   <= '0;
      timer       <= '0;
      cfg_ready_r <= 1'b1;
      det_r       <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      status_r    <= STAT_DONE;
      matches_r   <= '0;
    end else begin
      det_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pattern_q   <= bus.cfg_pattern;
`ifdef SEQ_DET_CTRL_MASK_EN
            mask_q      <= bus.cfg_mask;
`endif
            target_q    <= (bus.cfg_count == '0) ? CNT_W'(1) : bus.cfg_count;
            timeout_q   <= bus.cfg_timeout;
            match_cnt   <= '0;
            timer       <= '0;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state       <= ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (bus.abort) begin
            // Abort wins over everything; a match completing now is dropped.
            status_r    <= STAT_ABORTED;
            matches_r   <= match_cnt;
            res_valid_r <= 1'b1;
            state       <= ST_REPORT;
          end else begin
            det_r     <= match;
            match_cnt <= cnt_next;
            timer     <= timer + TMO_W'(1);
            if (cnt_next == target_q) begin
              status_r    <= STAT_DONE;
              matches_r   <= cnt_next;
              res_valid_r <= 1'b1;
              state       <= ST_REPORT;
            end else if (expire) begin
              status_r    <= STAT_TIMEOUT;
              matches_r   <= cnt_next;
              res_valid_r <= 1'b1;
              state       <= ST_REPORT;
            end
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready   = cfg_ready_r;
  assign bus.det_pulse   = det_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_status  = status_r;
  assign bus.res_matches = matches_r;
  assign bus.busy        = busy_r;
  assign fsm_state       = state;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus randomized
// commands, compared every cycle against a bit-history reference model.
module tb_seq_det_ctrl;
  import seq_det_ctrl_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int TMO_W = 16;
  localparam int RW    = CNT_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();
  state_t fsm_state;

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int busy_cnt = 0;
  logic [1:0]       last_status;
  logic [CNT_W-1:0] last_matches;
  logic [PAT_W-1:0] cfg_mask_v = '1;

  // ---------------- reference model ----------------
  logic [RW-1:0]    exp_q[$];
  logic             hist[$];
  int               m_phase;   // 0 idle, 1 hunting, 2 reporting
  int               m_cnt, m_target, m_tmo, m_elapsed;
  logic [PAT_W-1:0] m_pat, m_mask;
  logic             exp_cfg_ready, exp_det, exp_res_valid, exp_busy;
  logic [1:0]       exp_status;
  logic [CNT_W-1:0] exp_matches;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish(logic [1:0] s, int m);
    exp_status    = s;
    exp_matches   = CNT_W'(m);
    exp_res_valid = 1'b1;
    m_phase       = 2;
    exp_q.push_back({s, CNT_W'(m)});
  endtask

  // Predicts post-edge outputs from the inputs present before the edge.
  task automatic model_step();
    logic             hit;
    logic [PAT_W-1:0] win;
    if (rst) begin
      m_phase = 0; exp_cfg_ready = 1'b1; exp_det = 1'b0; exp_res_valid = 1'b0;
      exp_busy = 1'b0; exp_status = 2'b00; exp_matches = '0;
      exp_q.delete(); hist.delete();
      return;
    end
    exp_det = 1'b0;
    case (m_phase)
      0: if (bus.cfg_valid) begin
        m_pat = bus.cfg_pattern;
`ifdef SEQ_DET_CTRL_MASK_EN
        m_mask = bus.cfg_mask;
`else
        m_mask = '1;
`endif
        m_target = (bus.cfg_count == 0) ? 1 : int'(bus.cfg_count);
        m_tmo = int'(bus.cfg_timeout);
        hist.delete(); m_cnt = 0; m_elapsed = 0; m_phase = 1;
        exp_cfg_ready = 1'b0; exp_busy = 1'b1;
      end
      1: begin
        hit = 1'b0; win = '0;
        m_elapsed++;
        if (bus.bit_valid) begin
          hist.push_back(bus.bit_in);
          if (hist.size() > PAT_W) void'(hist.pop_front());
          if (hist.size() == PAT_W) begin
            for (int i = 0; i < PAT_W; i++) win[PAT_W-1-i] = hist[i];
            hit = (((win ^ m_pat) & m_mask) == '0);
          end
        end
        if (bus.abort) model_finish(2'b10, m_cnt);
        else begin
          exp_det = hit;
          if (hit && m_cnt < 2**CNT_W - 1) m_cnt++;
          if (m_cnt == m_target) model_finish(2'b00, m_cnt);
          else if (m_tmo != 0 && m_elapsed == m_tmo) model_finish(2'b01, m_cnt);
        end
      end
      default: if (bus.res_ready) begin
        m_phase = 0; exp_res_valid = 1'b0; exp_cfg_ready = 1'b1; exp_busy = 1'b0;
      end
    endcase
  endtask

  // One clock: advance the model, let the DUT clock, compare on the falling edge.
  task automatic cycle();
    logic             hs;
    logic [1:0]       st;
    logic [CNT_W-1:0] mt;
    logic [RW-1:0]    e;
    hs = (bus.res_valid === 1'b1) && bus.res_ready && !rst;
    st = bus.res_status;
    mt = bus.res_matches;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (hs) begin
      last_status = st;
      last_matches = mt;
      if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result_record", 32'({st, mt}), 32'(e));
      end
    end
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(exp_cfg_ready));
    chk("det_pulse", 32'(bus.det_pulse), 32'(exp_det));
    chk("res_valid", 32'(bus.res_valid), 32'(exp_res_valid));
    chk("res_status", 32'(bus.res_status), 32'(exp_status));
    chk("res_matches", 32'(bus.res_matches), 32'(exp_matches));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    if (bus.det_pulse === 1'b1) pulse_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.cfg_valid = 1'b0; bus.abort = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic send_cfg(logic [PAT_W-1:0] pat, logic [CNT_W-1:0] cnt, logic [TMO_W-1:0] tmo);
    logic acc;
    int   g;
    bus.cfg_valid = 1'b1; bus.cfg_pattern = pat; bus.cfg_count = cnt; bus.cfg_timeout = tmo;
`ifdef SEQ_DET_CTRL_MASK_EN
    bus.cfg_mask = cfg_mask_v;
`endif
    pulse_cnt = 0; busy_cnt = 0; g = 0;
    do begin
      acc = (bus.cfg_ready === 1'b1);
      cycle();
      g++;
    end while (!acc && g < 50);
    bus.cfg_valid = 1'b0;
    if (!acc) chk("cfg_accept_timeout", 0, 1);
  endtask

  task automatic send_bits(logic [15:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.bit_valid = 1'b1; bus.bit_in = bits[i];
      cycle();
    end
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int g;
    g = 0;
    while (bus.cfg_ready !== 1'b1 && g < 200) begin cycle(); g++; end
    chk({name, "_back_to_idle"}, 32'(g < 200), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    bus.cfg_pattern = '0; bus.cfg_count = '0; bus.cfg_timeout = '0; bus.res_ready = 1'b1;
`ifdef SEQ_DET_CTRL_MASK_EN
    bus.cfg_mask = '1;
`endif
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("reset_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("reset_res_valid", 32'(bus.res_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);

    // Overlapping matches: 1001 in 1001001 matches twice.
    send_cfg(4'b1001, 8'd2, 16'd0);
    send_bits(16'b1001001, 7);
    wait_idle("overlap");
    chk("overlap_status", 32'(last_status), 0);
    chk("overlap_matches", 32'(last_matches), 2);
    chk("overlap_pulses", pulse_cnt, 2);

    // Timeout after exactly 10 hunt cycles, plus one report cycle of busy.
    send_cfg(4'b1001, 8'd1, 16'd10);
    bus.bit_valid = 1'b1; bus.bit_in = 1'b0;
    wait_idle("timeout");
    idle_inputs();
    chk("timeout_status", 32'(last_status), 1);
    chk("timeout_matches", 32'(last_matches), 0);
    chk("timeout_pulses", pulse_cnt, 0);
    chk("timeout_busy_cycles", busy_cnt, 11);

    // Fill guard: 0000 cannot match before four zeros are in.
    send_cfg(4'b0000, 8'd3, 16'd0);
    send_bits(16'b000000, 6);
    wait_idle("fill");
    chk("fill_status", 32'(last_status), 0);
    chk("fill_matches", 32'(last_matches), 3);
    chk("fill_pulses", pulse_cnt, 3);

    // Abort collides with the completing bit of the second match.
    send_cfg(4'b1001, 8'd2, 16'd0);
    send_bits(16'b100100, 6);
    bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.abort = 1'b1;
    cycle();
    idle_inputs();
    wait_idle("abort");
    chk("abort_status", 32'(last_status), 2);
    chk("abort_matches", 32'(last_matches), 1);
    chk("abort_pulses", pulse_cnt, 1);

    // Backpressure: result held for 5 cycles, new command refused meanwhile.
    bus.res_ready = 1'b0;
    send_cfg(4'b1001, 8'd1, 16'd0);
    send_bits(16'b1001, 4);
    bus.cfg_valid = 1'b1; bus.cfg_pattern = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_res_valid", 32'(bus.res_valid), 1);
      chk("bp_cfg_ready", 32'(bus.cfg_ready), 0);
      chk("bp_status", 32'(bus.res_status), 0);
      chk("bp_matches", 32'(bus.res_matches), 1);
    end
    bus.cfg_valid = 1'b0;
    bus.res_ready = 1'b1;
    cycle();
    chk("bp_release_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("bp_release_res_valid", 32'(bus.res_valid), 0);

    // Reset mid-hunt after two matches, then a fresh command counts from zero.
    send_cfg(4'b1001, 8'd5, 16'd0);
    send_bits(16'b1001001, 7);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("rst_matches", 32'(bus.res_matches), 0);
    send_cfg(4'b1001, 8'd1, 16'd0);
    send_bits(16'b1001, 4);
    wait_idle("post_rst");
    chk("post_rst_status", 32'(last_status), 0);
    chk("post_rst_matches", 32'(last_matches), 1);

    // Randomized commands with random bit gaps, aborts and result backpressure.
    for (int k = 0; k < 40; k++) begin
      int g;
      int tmo;
      tmo = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 40) : 0;
      cfg_mask_v = PAT_W'($urandom_range(0, 15));
      send_cfg(PAT_W'($urandom_range(0, 15)), CNT_W'($urandom_range(0, 3)), TMO_W'(tmo));
      g = 0;
      while (m_phase != 0 && g < 300) begin
        bus.bit_valid = ($urandom_range(0, 3) != 0);
        bus.bit_in    = 1'($urandom_range(0, 1));
        bus.abort     = ($urandom_range(0, 63) == 0) || (g >= 150);
        bus.res_ready = 1'($urandom_range(0, 1));
        cycle();
        g++;
      end
      idle_inputs();
      bus.res_ready = 1'b1;
      chk("rand_cfg_ready", 32'(bus.cfg_ready), 1);
    end
    cfg_mask_v = '1;

    chk("results_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
